// File: rtl/fa_pkg.sv
// Shared fetch-path definitions: MIG instruction codes, cmd_fetch FSM encoding
// and cmd_fetch parameter defaults.
package fa_pkg;

  localparam logic [2:0] MIG_INSTR_WR = 3'b000;
  localparam logic [2:0] MIG_INSTR_RD = 3'b001;

  localparam int CMD_FETCH_BURST_LEN_DEF = 32;
  localparam int CMD_FETCH_FIFO_SIZE_DEF = 1023;
  localparam int CMD_FETCH_HEADROOM_DEF  = 20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } cmd_fetch_state_t;

  // Words in the next MIG burst: whatever is left, capped at the burst size.
  function automatic logic [6:0] burst_len_of(input logic [15:0] remaining,
                                              input logic [6:0]  burst_max);
    return (remaining < {9'd0, burst_max}) ? remaining[6:0] : burst_max;
  endfunction

endpackage

// File: rtl/cmd_fetch_if.sv
// MIG command/read port plus the write side of the downstream command FIFO,
// as seen by cmd_fetch (master) and by the MIG/FIFO side (slave).
interface cmd_fetch_if;

  logic        p_cmd_en;
  logic [2:0]  p_cmd_instr;
  logic [5:0]  p_cmd_bl;
  logic [29:0] p_cmd_byte_addr;
  logic        p_cmd_full;

  logic        p_rd_en;
  logic [31:0] p_rd_data;
  logic        p_rd_empty;

  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic [9:0]  fifo_wr_count;
  logic        fifo_full;

  modport master (
    output p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr,
    output p_rd_en, fifo_din, fifo_wr_en,
    input  p_cmd_full, p_rd_data, p_rd_empty, fifo_wr_count, fifo_full
  );

  modport slave (
    input  p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr,
    input  p_rd_en, fifo_din, fifo_wr_en,
    output p_cmd_full, p_rd_data, p_rd_empty, fifo_wr_count, fifo_full
  );

endinterface

// File: rtl/cmd_fetch.sv
// Fetches cmd_words words from DDR in MIG bursts into the command FIFO (FIFO write 1 cycle after MIG read);
// waits on calibration/FIFO headroom and p_cmd_full. CMD_FETCH_CHECKSUM_EN adds an XOR checksum output.
module cmd_fetch
  import fa_pkg::*;
#(
  parameter int BURST_LEN = CMD_FETCH_BURST_LEN_DEF,
  parameter int FIFO_SIZE = CMD_FETCH_FIFO_SIZE_DEF,
  parameter int HEADROOM  = CMD_FETCH_HEADROOM_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [29:0]        base_addr,
  input  logic [15:0]        cmd_words,
  input  logic               calib_done,
  cmd_fetch_if.master        bus,
  output logic               busy,
  output logic               done,
  output logic               overflow
`ifdef CMD_FETCH_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam int FILL_LIMIT = FIFO_SIZE - HEADROOM;

  cmd_fetch_state_t r_state;
  logic [29:0]      r_addr;
  logic [15:0]      r_remain;
  logic [6:0]       r_len;
  logic [6:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;
  logic             r_cmd_en;
  logic [2:0]       r_cmd_instr;
  logic [5:0]       r_cmd_bl;
  logic [29:0]      r_cmd_addr;
  logic [31:0]      r_din;
  logic             r_wr_vld;

  logic [6:0]       w_len;
  logic             w_room;
  logic             w_rd_acc;
  logic             w_last;
  logic             w_wr_acc;

  assign w_len    = burst_len_of(r_remain, 7'(BURST_LEN));
  // The FIFO count lags real occupancy, so the whole burst must fit below the headroom line.
  assign w_room   = (32'(bus.fifo_wr_count) + 32'(w_len)) <= 32'(FILL_LIMIT);
  assign w_rd_acc = (r_state == DRAIN) && !bus.p_rd_empty;
  assign w_last   = w_rd_acc && (r_cnt == r_len - 7'd1);
  assign w_wr_acc = r_wr_vld && !bus.fifo_full;

  assign bus.p_cmd_en        = r_cmd_en;
  assign bus.p_cmd_instr     = r_cmd_instr;
  assign bus.p_cmd_bl        = r_cmd_bl;
  assign bus.p_cmd_byte_addr = r_cmd_addr;
  assign bus.p_rd_en         = w_rd_acc;
  assign bus.fifo_din        = r_din;
  assign bus.fifo_wr_en      = w_wr_acc;

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_cmd_en    <= 1'b0;
      r_cmd_instr <= '0;
      r_cmd_bl    <= '0;
      r_cmd_addr  <= '0;
      r_din       <= '0;
      r_wr_vld    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_cmd_en <= 1'b0;
      r_wr_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_din <= bus.p_rd_data;
      end
      // A word arriving while the FIFO is full is lost; flag it until the next start.
      if (r_wr_vld && bus.fifo_full) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr     <= base_addr;
            r_remain   <= cmd_words;
            r_busy     <= 1'b1;
            r_overflow <= 1'b0;
            r_state    <= (cmd_words == 16'd0) ? FINISH : CHECK;
          end
        end
        CHECK: begin
          if (calib_done && w_room) begin
            r_len   <= w_len;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.p_cmd_full) begin
            r_cmd_en    <= 1'b1;
            r_cmd_instr <= MIG_INSTR_RD;
            r_cmd_bl    <= 6'(r_len - 7'd1);
            r_cmd_addr  <= r_addr;
            r_cnt       <= '0;
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_rd_acc) begin
            r_cnt <= r_cnt + 7'd1;
            if (w_last) begin
              r_addr   <= r_addr + {21'd0, r_len, 2'b00};
              r_remain <= r_remain - {9'd0, r_len};
              r_state  <= (r_remain == {9'd0, r_len}) ? FINISH : CHECK;
            end
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CMD_FETCH_CHECKSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_csum <= '0;
    end else if (w_wr_acc) begin
      r_csum <= r_csum ^ r_din;
    end
  end

  assign checksum = r_csum;
`endif

endmodule

// File: tb/tb_cmd_fetch.sv
// Bench for cmd_fetch: reactive MIG/FIFO responder, vector table, corner sequences,
// and random transfers checked against a burst-splitting reference model.
module tb_cmd_fetch;

  localparam int BL = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [29:0] base_addr;
  logic [15:0] cmd_words;
  logic        calib_done;
  logic        busy, done, overflow;
`ifdef CMD_FETCH_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  cmd_fetch_if bus();

  cmd_fetch #(.BURST_LEN(BL), .FIFO_SIZE(1023), .HEADROOM(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .cmd_words(cmd_words), .calib_done(calib_done), .bus(bus),
    .busy(busy), .done(done), .overflow(overflow)
`ifdef CMD_FETCH_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int          total = 0, bad = 0;
  int          cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0;
  bit          pop_pend = 1'b0, stall_mode = 1'b0, full_rnd = 1'b0, full_force = 1'b0;
  int          data_mode = 0;
  logic [31:0] rd_q[$];
  logic [5:0]  cmd_bl_q[$];
  logic [29:0] cmd_addr_q[$];
  logic [2:0]  cmd_instr_q[$];
  logic [31:0] wr_q[$];
  int          wr_cyc_q[$];

  // DDR contents as a function of byte address.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (data_mode == 1) return 32'd1 << a[6:2];
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // MIG + FIFO responder: drives read-port inputs at negedge, samples handshakes 1 unit later.
  initial begin
    bus.p_rd_empty = 1'b1;
    bus.p_rd_data  = '0;
    bus.p_cmd_full = 1'b0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (!rst_n) rd_q.delete();
      else if (pop_pend && rd_q.size() > 0) rd_q.delete(0);
      pop_pend = 1'b0;
      bus.p_rd_empty = (rd_q.size() == 0) || (stall_mode && $urandom_range(0, 2) == 0);
      bus.p_rd_data  = (rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_BEEF;
      bus.p_cmd_full = full_force || (full_rnd && $urandom_range(0, 2) == 0);
      #1;
      if (rst_n) begin
        if (bus.p_cmd_en) begin
          cmd_bl_q.push_back(bus.p_cmd_bl);
          cmd_addr_q.push_back(bus.p_cmd_byte_addr);
          cmd_instr_q.push_back(bus.p_cmd_instr);
          for (int i = 0; i <= int'(bus.p_cmd_bl); i++)
            rd_q.push_back(mem_word(bus.p_cmd_byte_addr + 30'(4 * i)));
        end
        if (bus.p_rd_en) pop_pend = 1'b1;
        if (bus.fifo_wr_en) begin
          wr_q.push_back(bus.fifo_din);
          wr_cyc_q.push_back(cyc);
        end
        if (done) begin
          done_cnt = done_cnt + 1;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    cmd_bl_q.delete(); cmd_addr_q.delete(); cmd_instr_q.delete();
    wr_q.delete(); wr_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [29:0] b, input int n);
    @(negedge clk); #2;
    start = 1'b1; base_addr = b; cmd_words = 16'(n); start_cyc = cyc;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int k = 0;
    while (done_cnt == 0 && k < 4000) begin @(negedge clk); #2; k++; end
    ok = (done_cnt != 0);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic run_xfer(input logic [29:0] b, input int n, output bit ok);
    clear_logs();
    pulse_start(b, n);
    wait_done(ok);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Reference: split n words into bursts of at most BL, addresses ascending mod 2^30.
  task automatic check_model(input string nm, input logic [29:0] b, input int n);
    int off, len, k, cbad, wbad;
    logic [29:0] a;
    logic [31:0] x;
    off = 0; k = 0; cbad = 0; wbad = 0; x = '0;
    while (off < n) begin
      len = (n - off < BL) ? (n - off) : BL;
      a   = b + 30'(4 * off);
      if (k >= cmd_bl_q.size()) cbad++;
      else if (cmd_bl_q[k] != 6'(len - 1) || cmd_addr_q[k] != a || cmd_instr_q[k] != 3'b001) cbad++;
      off += len;
      k++;
    end
    chk({nm, "/ncmd"}, cmd_bl_q.size(), k);
    chk({nm, "/cmds"}, cbad, 0);
    chk({nm, "/nwr"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      x = x ^ mem_word(b + 30'(4 * i));
      if (wr_q[i] !== mem_word(b + 30'(4 * i))) wbad++;
    end
    chk({nm, "/data"}, wbad, 0);
`ifdef CMD_FETCH_CHECKSUM_EN
    chk({nm, "/csum"}, checksum, x);
`endif
  endtask

  task automatic check_done(input string nm, input int n, input bit ok);
    chk({nm, "/done"}, ok, 1);
    chk({nm, "/done_once"}, done_cnt, 1);
    chk({nm, "/busy_end"}, busy, 0);
    if (n == 0) chk({nm, "/done_lat"}, (done_cyc - start_cyc) <= 3, 1);
    else if (wr_cyc_q.size() > 0) chk({nm, "/done_lat"}, done_cyc - wr_cyc_q[$], 1);
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, "/ctrl"}, {busy, done, overflow, bus.p_cmd_en, bus.p_rd_en, bus.fifo_wr_en,
                        bus.p_cmd_instr, bus.p_cmd_bl}, 0);
    chk({nm, "/addr"}, bus.p_cmd_byte_addr, 0);
    chk({nm, "/din"}, bus.fifo_din, 0);
  endtask

  typedef struct {
    logic [29:0] base;
    int          words;
    int          ncmd;
    logic [5:0]  last_bl;
    logic [29:0] last_addr;
  } vec_t;

  initial begin
    vec_t        vt[8];
    bit          ok;
    int          k;
    logic [29:0] rb;
    int          rn;

    #500_000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
    vt[0] = '{30'h100, 5, 1, 6'd4, 30'h100};
  end

  initial begin
    vec_t        vt[8];
    bit          ok;
    int          k;
    logic [29:0] rb;
    int          rn;

    vt[0] = '{30'h0000_0100,  5, 1, 6'd4,  30'h0000_0100};
    vt[1] = '{30'h0000_2000, 70, 3, 6'd5,  30'h0000_2100};
    vt[2] = '{30'h0000_0300,  0, 0, 6'd0,  30'h0000_0000};
    vt[3] = '{30'h0000_0040,  1, 1, 6'd0,  30'h0000_0040};
    vt[4] = '{30'h0000_0800, 32, 1, 6'd31, 30'h0000_0800};
    vt[5] = '{30'h0000_0900, 33, 2, 6'd0,  30'h0000_0980};
    vt[6] = '{30'h3FFF_FFC0, 40, 2, 6'd7,  30'h0000_0040};
    vt[7] = '{30'h0000_1000, 64, 2, 6'd31, 30'h0000_1080};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; cmd_words = '0; calib_done = 1'b1;
    bus.fifo_wr_count = '0; bus.fifo_full = 1'b0;
    wait_cycles(3);
    check_reset_outs("reset");
    rst_n = 1'b1;
    wait_cycles(2);
    chk("idle/busy", busy, 0);

    for (int v = 0; v < 8; v++) begin
      run_xfer(vt[v].base, vt[v].words, ok);
      chk($sformatf("vec%0d/ncmd", v), cmd_bl_q.size(), vt[v].ncmd);
      if (cmd_bl_q.size() > 0) begin
        chk($sformatf("vec%0d/last_bl", v), cmd_bl_q[$], vt[v].last_bl);
        chk($sformatf("vec%0d/last_addr", v), cmd_addr_q[$], vt[v].last_addr);
      end
      check_model($sformatf("vec%0d", v), vt[v].base, vt[v].words);
      check_done($sformatf("vec%0d", v), vt[v].words, ok);
    end

    // FIFO headroom boundary: 990 and 972 hold in CHECK, 971 lets a 32-word burst go.
    clear_logs();
    bus.fifo_wr_count = 10'd990;
    pulse_start(30'h4000, 64);
    wait_cycles(15);
    chk("thr990/nocmd", cmd_bl_q.size(), 0);
    chk("thr990/busy", busy, 1);
    bus.fifo_wr_count = 10'd972;
    wait_cycles(10);
    chk("thr972/nocmd", cmd_bl_q.size(), 0);
    bus.fifo_wr_count = 10'd971;
    k = 0;
    while (cmd_bl_q.size() == 0 && k < 10) begin @(negedge clk); #2; k++; end
    chk("thr971/lat", k, 2);
    wait_done(ok);
    check_model("thr", 30'h4000, 64);
    check_done("thr", 64, ok);
    bus.fifo_wr_count = '0;

    clear_logs();
    calib_done = 1'b0;
    pulse_start(30'h4400, 5);
    wait_cycles(10);
    chk("calib/nocmd", cmd_bl_q.size(), 0);
    calib_done = 1'b1;
    wait_done(ok);
    check_model("calib", 30'h4400, 5);
    check_done("calib", 5, ok);

    clear_logs();
    full_force = 1'b1;
    pulse_start(30'h4800, 5);
    wait_cycles(10);
    chk("cmdfull/nocmd", cmd_bl_q.size(), 0);
    full_force = 1'b0;
    wait_done(ok);
    check_model("cmdfull", 30'h4800, 5);
    check_done("cmdfull", 5, ok);

    bus.fifo_full = 1'b1;
    run_xfer(30'h5000, 8, ok);
    chk("ovf/nwr", wr_q.size(), 0);
    chk("ovf/flag", overflow, 1);
    chk("ovf/done", ok, 1);
    wait_cycles(4);
    chk("ovf/sticky", overflow, 1);
    bus.fifo_full = 1'b0;
    run_xfer(30'h5100, 4, ok);
    chk("ovf/cleared", overflow, 0);
    check_model("ovf_after", 30'h5100, 4);

    clear_logs();
    pulse_start(30'h7000, 40);
    wait_cycles(4);
    start = 1'b1; base_addr = 30'h9000; cmd_words = 16'd3;
    wait_cycles(1);
    start = 1'b0;
    wait_done(ok);
    wait_cycles(3);
    check_model("busystart", 30'h7000, 40);
    check_done("busystart", 40, ok);

    // Reset while draining: outputs drop at once and the transfer is abandoned.
    clear_logs();
    stall_mode = 1'b1;
    pulse_start(30'h6000, 32);
    k = 0;
    while (wr_q.size() < 3 && k < 300) begin @(negedge clk); #2; k++; end
    chk("rstdrain/reached", wr_q.size() >= 3, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rstdrain");
    wait_cycles(2);
    rst_n = 1'b1;
    stall_mode = 1'b0;
    clear_logs();
    wait_cycles(8);
    chk("rstdrain/abandon", {busy, 1'b0} | 2'(done_cnt != 0), 0);
    run_xfer(30'h6100, 10, ok);
    check_model("recover", 30'h6100, 10);
    check_done("recover", 10, ok);

`ifdef CMD_FETCH_CHECKSUM_EN
    data_mode = 1;
    run_xfer(30'h0, 3, ok);
    chk("csum/147", checksum, 32'h7);
    data_mode = 0;
`endif

    for (int it = 0; it < 20; it++) begin
      rb = 30'($urandom()) & ~30'h3;
      rn = $urandom_range(0, 150);
      stall_mode = 1'($urandom_range(0, 1));
      full_rnd   = 1'($urandom_range(0, 1));
      bus.fifo_wr_count = 10'($urandom_range(0, 971));
      run_xfer(rb, rn, ok);
      check_model($sformatf("rnd%0d", it), rb, rn);
      check_done($sformatf("rnd%0d", it), rn, ok);
    end
    stall_mode = 1'b0;
    full_rnd   = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_fetch.md
CMD_FETCH -- requirements
Module: cmd_fetch

Interface
REQ-001 SHALL have parameter BURST_LEN, default 32, meaning maximum words per MIG read command (1..64).
REQ-002 SHALL have parameter FIFO_SIZE, default 1023, meaning usable depth of the downstream command FIFO.
REQ-003 SHALL have parameter HEADROOM, default 20, meaning FIFO count slack for count-update latency.
REQ-004 SHALL have ports: clk  in  1  sole clock (MIG user clock domain); rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: start  in  1  one-cycle request pulse; base_addr  in  30  byte address of first command word (4-byte aligned); cmd_words  in  16  number of 32-bit words to fetch.
REQ-006 SHALL have ports: calib_done  in  1  MIG calibration complete; p_cmd_en  out  1; p_cmd_instr  out  3; p_cmd_bl  out  6; p_cmd_byte_addr  out  30; p_cmd_full  in  1.
REQ-007 SHALL have ports: p_rd_en  out  1; p_rd_data  in  32; p_rd_empty  in  1 (MIG read port, first-word-fall-through).
REQ-008 SHALL have ports: fifo_din  out  32; fifo_wr_en  out  1; fifo_wr_count  in  10; fifo_full  in  1 (write side of CSB command FIFO).
REQ-009 SHALL have ports: busy  out  1; done  out  1 (one-cycle pulse); overflow  out  1 (sticky).

Function
REQ-010 SHALL implement FSM states IDLE, CHECK, ISSUE, DRAIN, FINISH.
REQ-011 IDLE: on start, latch base_addr and cmd_words, set busy; go to FINISH if cmd_words==0, else CHECK; start while busy SHALL be ignored.
REQ-012 CHECK: compute len = min(remaining, BURST_LEN); go to ISSUE only when calib_done==1 and fifo_wr_count <= FIFO_SIZE-HEADROOM-len.
REQ-013 ISSUE: when p_cmd_full==0, assert p_cmd_en for exactly one cycle with p_cmd_instr=3'b001 (read), p_cmd_bl=len-1, p_cmd_byte_addr=current address; go to DRAIN.
REQ-014 DRAIN: p_rd_en = ~p_rd_empty; every accepted word SHALL be presented on fifo_din with fifo_wr_en high on the following cycle (1-cycle latency, registered).
REQ-015 After len words are accepted, address SHALL advance by len*4 and remaining decrease by len; go to CHECK if remaining>0, else FINISH.
REQ-016 FINISH: pulse done for one cycle, clear busy, return to IDLE.
REQ-017 Address arithmetic SHALL wrap modulo 2^30; remaining SHALL be 16-bit and never underflow.
REQ-018 If fifo_wr_en would be asserted while fifo_full==1, the word SHALL be dropped and overflow set; overflow cleared only by reset or by the next accepted start.
REQ-019 Word order into the FIFO SHALL equal ascending DDR address order.

Reset
REQ-020 On rst_n low, asynchronously: state=IDLE, busy=0, done=0, overflow=0, p_cmd_en=0, p_rd_en=0, fifo_wr_en=0, p_cmd_instr=0, p_cmd_bl=0, p_cmd_byte_addr=0, fifo_din=0.
REQ-021 Reset mid-operation SHALL abandon the transfer without draining the MIG read port; the MIG port reset is the system's responsibility.

Configuration
REQ-022 Macro CMD_FETCH_CHECKSUM_EN, when defined, SHALL add output checksum (32 bits): XOR of all words written to the FIFO since the last accepted start, valid when done pulses, reset to 0.
REQ-023 Without CMD_FETCH_CHECKSUM_EN, the checksum port and logic SHALL not exist; all other behaviour identical.

Structure
REQ-024 A shared package fa_pkg SHALL hold the MIG instruction codes (read 3'b001, write 3'b000), the cmd_fetch FSM state encoding, and defaults for BURST_LEN, FIFO_SIZE and HEADROOM.
REQ-025 The module SHALL be flat; no sub-module.

Verification
REQ-026 start, base 0x100, cmd_words=5, MIG model returning 5 words -> one command with bl=4 at address 0x100; 5 FIFO writes in order; done 1 cycle after last write.
REQ-027 cmd_words=70, BURST_LEN=32 -> commands bl=31@base, bl=31@base+128, bl=5@base+256; 70 writes in order.
REQ-028 cmd_words=0 -> no p_cmd_en; done within 3 cycles of start.
REQ-029 fifo_wr_count=990 with len=32 -> stays in CHECK; lowering the count to 971 -> command issued next cycle; p_cmd_full held high 10 cycles -> p_cmd_en is delayed, still asserted once.
REQ-030 fifo_full forced high during DRAIN -> word dropped, overflow=1; rst_n low mid-DRAIN -> all outputs at reset values immediately.
REQ-031 With CMD_FETCH_CHECKSUM_EN, words 0x1,0x2,0x4 -> checksum=0x7 when done pulses.
